// File: rtl/sysid_reader.sv
// rtl/sysid_reader.sv - Avalon-MM read master that fetches and checks system ID and build timestamp.
// Reads word 0 then word 1 back-to-back, compares against expected values, reports a one-cycle done.
module sysid_reader #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5B40_CE93,
  parameter bit          CHECK_TS           = 1'b1,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_RD_ID, S_RD_TS, S_CHECK, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_addr;
  logic          r_read;
  logic          r_busy;
  logic          r_done;
  logic          r_id_ok;
  logic          r_ts_ok;
  logic          r_pass;
  logic          r_timeout;
  logic [31:0]   r_read_id;
  logic [31:0]   r_read_ts;

  logic w_to_hit;
  logic w_id_ok;
  logic w_ts_ok;

  // Abort once the current read has stalled for TIMEOUT_CYCLES consecutive cycles.
  assign w_to_hit = (TIMEOUT_CYCLES != 0) && avm_waitrequest && (r_cnt == TO_LAST);
  assign w_id_ok  = (r_read_id == EXPECTED_ID);
  assign w_ts_ok  = CHECK_TS ? (r_read_ts == EXPECTED_TIMESTAMP) : 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= 1'b0;
      r_read    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_id_ok   <= 1'b0;
      r_ts_ok   <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_read_id <= '0;
      r_read_ts <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RD_ID;
            r_read    <= 1'b1;
            r_addr    <= 1'b0;
            r_busy    <= 1'b1;
            r_id_ok   <= 1'b0;
            r_ts_ok   <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
          end
        end
        S_RD_ID: begin
          if (!avm_waitrequest) begin
            r_read_id <= avm_readdata;
            r_cnt     <= '0;
            r_addr    <= 1'b1;
            r_state   <= S_RD_TS;
          end else if (w_to_hit) begin
            r_timeout <= 1'b1;
            r_read    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RD_TS: begin
          if (!avm_waitrequest) begin
            r_read_ts <= avm_readdata;
            r_read    <= 1'b0;
            r_state   <= S_CHECK;
          end else if (w_to_hit) begin
            r_timeout <= 1'b1;
            r_read    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CHECK: begin
          r_id_ok <= w_id_ok;
          r_ts_ok <= w_ts_ok;
          r_pass  <= w_id_ok && w_ts_ok;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign avm_address = r_addr;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign pass        = r_pass;
  assign timeout     = r_timeout;
  assign read_id     = r_read_id;
  assign read_ts     = r_read_ts;

endmodule

// File: tb/tb_sysid_reader.sv
// tb/tb_sysid_reader.sv - Directed self-checking bench for sysid_reader.
// Instance a uses default parameters; instance b has CHECK_TS=0 and TIMEOUT_CYCLES=4.
module tb_sysid_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st_a = 1'b0, st_b = 1'b0;
  logic wr_a = 1'b0, wr_b = 1'b0;
  logic [31:0] id_val = 32'h0;
  logic [31:0] ts_val = 32'h5B40_CE93;

  logic        a_addr, a_read, a_busy, a_done, a_id_ok, a_ts_ok, a_pass, a_timeout;
  logic [31:0] a_read_id, a_read_ts, a_rdata;
  logic        b_addr, b_read, b_busy, b_done, b_id_ok, b_ts_ok, b_pass, b_timeout;
  logic [31:0] b_read_id, b_read_ts, b_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign a_rdata = a_addr ? ts_val : id_val;
  assign b_rdata = b_addr ? ts_val : id_val;

  sysid_reader dut_a (
    .clock(clk), .reset(rst), .start(st_a),
    .avm_address(a_addr), .avm_read(a_read),
    .avm_waitrequest(wr_a), .avm_readdata(a_rdata),
    .busy(a_busy), .done(a_done), .id_ok(a_id_ok), .ts_ok(a_ts_ok),
    .pass(a_pass), .timeout(a_timeout), .read_id(a_read_id), .read_ts(a_read_ts)
  );

  sysid_reader #(.CHECK_TS(1'b0), .TIMEOUT_CYCLES(4)) dut_b (
    .clock(clk), .reset(rst), .start(st_b),
    .avm_address(b_addr), .avm_read(b_read),
    .avm_waitrequest(wr_b), .avm_readdata(b_rdata),
    .busy(b_busy), .done(b_done), .id_ok(b_id_ok), .ts_ok(b_ts_ok),
    .pass(b_pass), .timeout(b_timeout), .read_id(b_read_id), .read_ts(b_read_ts)
  );

  // Drive inputs for the current cycle, then advance to the next cycle's negedge.
  task automatic step(input logic sa, input logic wa, input logic sb, input logic wb);
    st_a = sa; wr_a = wa; st_b = sb; wr_b = wb;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    total++;
    if ({a_read, a_addr, a_busy, a_done, a_id_ok, a_ts_ok, a_pass, a_timeout, a_read_id, a_read_ts} !== 72'h0) begin
      bad++;
      $display("FAIL reset_a: got %h want 0",
        {a_read, a_addr, a_busy, a_done, a_id_ok, a_ts_ok, a_pass, a_timeout, a_read_id, a_read_ts});
    end
    total++;
    if ({b_read, b_busy, b_done, b_timeout} !== 4'h0) begin
      bad++;
      $display("FAIL reset_b: got %b want 0000", {b_read, b_busy, b_done, b_timeout});
    end
    rst = 1'b0;
    step(0, 0, 0, 0);
  endtask

  task automatic test_zero_wait;
    int done_c;
    bit seq_ok;
    done_c = -1;
    seq_ok = 1'b1;
    id_val = 32'h0;
    ts_val = 32'h5B40_CE93;
    step(1, 0, 0, 0);
    for (int c = 1; c <= 8; c++) begin
      if (c == 1 && !(a_read === 1'b1 && a_addr === 1'b0 && a_busy === 1'b1)) seq_ok = 1'b0;
      if (c == 2 && !(a_read === 1'b1 && a_addr === 1'b1)) seq_ok = 1'b0;
      if (c == 3 && !(a_read === 1'b0 && a_busy === 1'b1)) seq_ok = 1'b0;
      if (a_done === 1'b1 && done_c < 0) done_c = c;
      step(0, 0, 0, 0);
    end
    total++;
    if (!seq_ok) begin bad++; $display("FAIL zw_read_sequence: got bad strobe/address sequence want rd0@1 rd1@2 idle@3"); end
    total++;
    if (done_c != 4) begin bad++; $display("FAIL zw_done_cycle: got %0d want 4", done_c); end
    total++;
    if ({a_pass, a_id_ok, a_ts_ok, a_timeout, a_busy} !== 5'b11100) begin
      bad++; $display("FAIL zw_flags: got %b want 11100", {a_pass, a_id_ok, a_ts_ok, a_timeout, a_busy});
    end
    total++;
    if (a_read_ts !== 32'h5B40_CE93) begin bad++; $display("FAIL zw_read_ts: got %h want 5b40ce93", a_read_ts); end
  endtask

  task automatic test_bad_ts;
    ts_val = 32'h5B40_CE94;
    step(1, 0, 1, 0);
    for (int c = 1; c <= 8; c++) step(0, 0, 0, 0);
    total++;
    if ({a_id_ok, a_ts_ok, a_pass} !== 3'b100) begin
      bad++; $display("FAIL badts_a_flags: got %b want 100", {a_id_ok, a_ts_ok, a_pass});
    end
    total++;
    if ({b_id_ok, b_ts_ok, b_pass} !== 3'b111) begin
      bad++; $display("FAIL badts_nocheck_flags: got %b want 111", {b_id_ok, b_ts_ok, b_pass});
    end
    ts_val = 32'h5B40_CE93;
  endtask

  task automatic test_stall;
    int done_c;
    bit stable;
    logic w;
    done_c = -1;
    stable = 1'b1;
    step(1, 0, 0, 0);
    for (int c = 1; c <= 14; c++) begin
      w = ((c >= 1 && c <= 3) || (c >= 5 && c <= 7));
      if (c <= 4 && !(a_read === 1'b1 && a_addr === 1'b0)) stable = 1'b0;
      if (c >= 5 && c <= 8 && !(a_read === 1'b1 && a_addr === 1'b1)) stable = 1'b0;
      if (a_done === 1'b1 && done_c < 0) done_c = c;
      step(0, w, 0, 0);
    end
    total++;
    if (!stable) begin bad++; $display("FAIL stall_stable: got strobe/address change during stall want stable"); end
    total++;
    if (done_c != 10) begin bad++; $display("FAIL stall_done_cycle: got %0d want 10", done_c); end
    total++;
    if (a_pass !== 1'b1) begin bad++; $display("FAIL stall_pass: got %b want 1", a_pass); end
  endtask

  task automatic test_timeout;
    bit rd_held;
    logic [3:0] at6;
    rd_held = 1'b1;
    at6 = 4'h0;
    id_val = 32'h1234_5678;
    step(0, 0, 1, 0);
    for (int c = 1; c <= 8; c++) begin
      if (c >= 2 && c <= 5 && !(b_read === 1'b1 && b_addr === 1'b1)) rd_held = 1'b0;
      if (c == 6) at6 = {b_read, b_done, b_timeout, b_pass};
      step(0, 0, 0, (c >= 2));
    end
    step(0, 0, 0, 0);
    total++;
    if (!rd_held) begin bad++; $display("FAIL to_read_held: got read dropped before 4th stall want held"); end
    total++;
    if (at6 !== 4'b0110) begin bad++; $display("FAIL to_abort: got read,done,timeout,pass=%b want 0110", at6); end
    total++;
    if (b_read_id !== 32'h1234_5678) begin bad++; $display("FAIL to_read_id: got %h want 12345678", b_read_id); end
    total++;
    if (b_read_ts !== 32'h5B40_CE94) begin bad++; $display("FAIL to_read_ts_kept: got %h want 5b40ce94", b_read_ts); end
    total++;
    if ({b_id_ok, b_ts_ok, b_pass, b_timeout} !== 4'b0001) begin
      bad++; $display("FAIL to_flags_hold: got %b want 0001", {b_id_ok, b_ts_ok, b_pass, b_timeout});
    end
    id_val = 32'h0;
  endtask

  task automatic test_back_to_back;
    int dones;
    bit saw0, saw1;
    dones = 0;
    step(1, 0, 0, 0);
    for (int c = 1; c <= 10; c++) begin
      if (a_done === 1'b1) dones++;
      step((c == 2), 0, 0, 0);
    end
    total++;
    if (dones != 1) begin bad++; $display("FAIL b2b_ignored_start: got %0d done pulses want 1", dones); end
    dones = 0;
    saw0 = 1'b0;
    saw1 = 1'b0;
    step(1, 0, 0, 0);
    for (int c = 1; c <= 10; c++) begin
      if (a_done === 1'b1) dones++;
      if (a_read === 1'b1 && a_addr === 1'b0) saw0 = 1'b1;
      if (a_read === 1'b1 && a_addr === 1'b1) saw1 = 1'b1;
      step(0, 0, 0, 0);
    end
    total++;
    if ({dones == 1, saw0, saw1, a_pass} !== 4'b1111) begin
      bad++; $display("FAIL b2b_rerun: got dones=%0d rd0=%b rd1=%b pass=%b want 1 1 1 1", dones, saw0, saw1, a_pass);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    rst = 1'b1;
    step(0, 1, 0, 0);
    total++;
    if ({a_read, a_addr, a_busy, a_done, a_id_ok, a_ts_ok, a_pass, a_timeout, a_read_id, a_read_ts} !== 72'h0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h want 0",
        {a_read, a_addr, a_busy, a_done, a_id_ok, a_ts_ok, a_pass, a_timeout, a_read_id, a_read_ts});
    end
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      if (a_done === 1'b1) dones++;
      step(0, 0, 0, 0);
    end
    total++;
    if (dones != 0) begin bad++; $display("FAIL midreset_no_done: got %0d done pulses want 0", dones); end
    dones = 0;
    step(1, 0, 0, 0);
    for (int c = 1; c <= 8; c++) begin
      if (a_done === 1'b1) dones++;
      step(0, 0, 0, 0);
    end
    total++;
    if (dones != 1 || a_pass !== 1'b1 || a_read_ts !== 32'h5B40_CE93) begin
      bad++; $display("FAIL midreset_rerun: got dones=%0d pass=%b ts=%h want 1 1 5b40ce93", dones, a_pass, a_read_ts);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_zero_wait;
    test_bad_ts;
    test_stall;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
